// File: rtl/if_bram_stream_reader_pkg.sv
// Shared constants and FSM state type for the input-feature BRAM read streamer.
package if_bram_pkg;
    localparam int IF_DATA_W     = 40;
    localparam int IF_DEPTH      = 205;
    localparam int IF_ADDR_W     = 8;
    localparam int IF_READ_LAT   = 2;
    localparam int IF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_t;
endpackage

// File: rtl/if_bram_stream_reader_if.sv
// Valid/ready word stream from the BRAM reader towards the PE array.
interface if_bram_stream_reader_if
    import if_bram_pkg::*;
#(
    parameter int DATA_W = IF_DATA_W
);
    logic              valid;
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/if_bram_stream_reader_fifo.sv
// Small synchronous FIFO holding {last, data} words returned by the BRAM.
module if_rd_fifo #(
    parameter int  W     = 41,
    parameter int  DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clka,
    input  logic             rstb,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clka) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
endmodule

// File: rtl/if_bram_stream_reader.sv
// Streams len words from the input-feature BRAM starting at base_addr onto a valid/ready port.
// Define IF_READER_PERF_CNT_EN to add the stall_cycles backpressure counter output.
module if_bram_stream_reader
    import if_bram_pkg::*;
#(
    parameter int DATA_W     = IF_DATA_W,
    parameter int DEPTH      = IF_DEPTH,
    parameter int ADDR_W     = IF_ADDR_W,
    parameter int READ_LAT   = IF_READ_LAT,
    parameter int FIFO_DEPTH = IF_FIFO_DEPTH
) (
    input  logic              clka,
    input  logic              rstb,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic              bram_regce,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    if_bram_stream_reader_if.master m
`ifdef IF_READER_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   MAX_LEN   = (ADDR_W + 1)'(DEPTH);

    rd_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                busy_q, busy_d, done_q, done_d, regce_q, regce_d;
    logic [READ_LAT-1:0] vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;

    logic                issue, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_W:0]     fifo_dout;
    int                  credit;

    // Every issued read owns a FIFO slot until it is popped, so the push never stalls.
    always_comb begin
        credit = FIFO_DEPTH - int'(fifo_count) - $countones(vld_pipe_q);
        issue  = (state_q == RUN) && (credit > 0) && !fifo_full;
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rem_d          = rem_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        regce_d        = regce_q;
        vld_pipe_d     = vld_pipe_q << 1;
        last_pipe_d    = last_pipe_q << 1;
        vld_pipe_d[0]  = issue;
        last_pipe_d[0] = issue && (rem_q == (ADDR_W + 1)'(1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        regce_d = 1'b1;
                        addr_d  = (base_addr > LAST_ADDR) ? '0 : base_addr;
                        rem_d   = (len > MAX_LEN) ? MAX_LEN : len;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == (ADDR_W + 1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Finish in the cycle the final beat leaves so done follows it by one cycle.
                if (vld_pipe_q == '0 &&
                    (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    regce_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                regce_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            regce_q     <= 1'b0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            regce_q     <= regce_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign bram_en    = issue;
    assign bram_regce = regce_q;
    assign bram_addr  = addr_q;

    assign pop = m.valid && m.ready;

    if_rd_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clka  (clka),
        .rstb  (rstb),
        .push  (vld_pipe_q[READ_LAT-1]),
        .din   ({last_pipe_q[READ_LAT-1], bram_dout}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m.valid = !fifo_empty;
    assign m.data  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
    assign m.last  = !fifo_empty && fifo_dout[DATA_W];

`ifdef IF_READER_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start)
            stall_d = '0;
        else if (busy_q && m.valid && !m.ready && stall_q != '1)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clka) begin
        if (rstb) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_if_bram_stream_reader.sv
// Directed + randomized bench for if_bram_stream_reader against a queue-based reference model.
module tb_if_bram_stream_reader;
    import if_bram_pkg::*;

    logic        clka = 1'b0;
    logic        rstb = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  len = '0;
    logic        busy, done, bram_en, bram_regce;
    logic [7:0]  bram_addr;
    logic [39:0] bram_dout = '0;
`ifdef IF_READER_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    if_bram_stream_reader_if #(.DATA_W(IF_DATA_W)) s_if ();

    logic [39:0] mem [256];
    logic [39:0] r1 = '0;
    int          checks = 0, errors = 0;
    int          cyc = 0, done_total = 0, done_cyc = 0, last_beat_cyc = 0;
    int          iss_q[$], iss_cyc[$];
    logic [40:0] beat_q[$];

    always #5 clka = ~clka;

    if_bram_stream_reader dut (
        .clka       (clka),
        .rstb       (rstb),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .bram_en    (bram_en),
        .bram_regce (bram_regce),
        .bram_addr  (bram_addr),
        .bram_dout  (bram_dout),
        .m          (s_if)
`ifdef IF_READER_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Two-stage BRAM port A: array latch on en, output register on regce.
    always @(posedge clka) begin
        if (bram_en) r1 <= mem[bram_addr];
        if (bram_regce) bram_dout <= r1;
    end

    always @(negedge clka) begin
        cyc++;
        if (bram_en) begin
            iss_q.push_back(int'(bram_addr));
            iss_cyc.push_back(cyc);
        end
        if (s_if.valid && s_if.ready) begin
            beat_q.push_back({s_if.last, s_if.data});
            if (s_if.last) last_beat_cyc = cyc;
        end
        if (done) begin
            done_total++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_en"},    bram_en, 0);
        chk({tag, "_regce"}, bram_regce, 0);
        chk({tag, "_addr"},  bram_addr, 0);
        chk({tag, "_valid"}, s_if.valid, 0);
        chk({tag, "_data"},  s_if.data, 0);
        chk({tag, "_last"},  s_if.last, 0);
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low 10 cycles after first beat;
    // 3: extra start while busy plus exactly 6 stalled beats
    task automatic run_cmd(input string tag, input int b, input int l, input int mode);
        int i0, b0, d0, n, bb, budget, hold, stall_left, a;
        bit ign_sent;
        i0 = iss_q.size();
        b0 = beat_q.size();
        d0 = done_total;
        n  = (l > IF_DEPTH) ? IF_DEPTH : l;
        bb = (b >= IF_DEPTH) ? 0 : b;
        base_addr  = 8'(b);
        len        = 9'(l);
        start      = 1'b1;
        s_if.ready = 1'b1;
        tick();
        start = 1'b0; hold = 0; stall_left = 6; ign_sent = 1'b0; budget = 3000;
        while (done_total == d0 && budget > 0) begin
            case (mode)
                1: s_if.ready = 1'($urandom_range(0, 1));
                2: begin
                    if (beat_q.size() > b0 && hold < 10) begin
                        s_if.ready = 1'b0;
                        hold++;
                        chk({tag, "_outstanding_le_fifo"},
                            ((iss_q.size() - i0) - (beat_q.size() - b0)) <= 4, 1);
                        if (hold == 10) chk({tag, "_issued_during_stall"}, iss_q.size() - i0, 5);
                    end else begin
                        s_if.ready = 1'b1;
                    end
                end
                3: begin
                    if (!ign_sent) begin
                        start = 1'b1; base_addr = 8'd50; len = 9'd3; ign_sent = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                    if (stall_left > 0 && s_if.valid) begin
                        s_if.ready = 1'b0;
                        stall_left--;
                    end else begin
                        s_if.ready = 1'b1;
                    end
                end
                default: s_if.ready = 1'b1;
            endcase
            tick();
            budget--;
        end
        start = 1'b0;
        s_if.ready = 1'b1;
        chk({tag, "_done_once"}, done_total - d0, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_n_issued"}, iss_q.size() - i0, n);
        chk({tag, "_n_beats"}, beat_q.size() - b0, n);
        for (int i = 0; i < n; i++) begin
            a = (bb + i) % IF_DEPTH;
            if (i0 + i < iss_q.size()) chk({tag, "_addr"}, iss_q[i0 + i], a);
            if (b0 + i < beat_q.size()) chk({tag, "_beat"}, beat_q[b0 + i], {(i == n - 1), mem[a]});
        end
        if (n > 0) chk({tag, "_done_after_last"}, done_cyc, last_beat_cyc + 1);
        if (mode == 0 && n > 0 && iss_cyc.size() >= i0 + n)
            chk({tag, "_issue_back_to_back"}, iss_cyc[i0 + n - 1] - iss_cyc[i0], n - 1);
    endtask

    initial begin
        int i0, b0, d0, c0;
        for (int i = 0; i < 256; i++) mem[i] = {8'($urandom), $urandom};
        s_if.ready = 1'b0;
        rstb = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("reset");
        rstb = 1'b0;
        tick();

        run_cmd("basic", 10, 5, 0);
        run_cmd("wrap", 200, 10, 0);
        run_cmd("backpressure", 0, 8, 2);

        // zero-length command: done only, no BRAM or stream activity
        i0 = iss_q.size(); b0 = beat_q.size(); d0 = done_total; c0 = cyc;
        base_addr = 8'd7; len = 9'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("len0_done_once", done_total - d0, 1);
        chk("len0_no_issue", iss_q.size() - i0, 0);
        chk("len0_no_beat", beat_q.size() - b0, 0);
        chk("len0_done_latency", (done_cyc - (c0 + 1)) >= 1 && (done_cyc - (c0 + 1)) <= 2, 1);

        // abort mid-RUN with words stuck in flight
        base_addr = 8'd0; len = 9'd20; start = 1'b1; s_if.ready = 1'b0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort_busy_before", busy, 1);
        rstb = 1'b1;
        tick();
        chk_idle_outputs("abort_rst");
        rstb = 1'b0;
        i0 = iss_q.size(); b0 = beat_q.size(); d0 = done_total;
        s_if.ready = 1'b1;
        repeat (8) tick();
        chk("abort_no_done", done_total - d0, 0);
        chk("abort_no_issue", iss_q.size() - i0, 0);
        chk("abort_no_beat", beat_q.size() - b0, 0);
        run_cmd("after_abort", 100, 4, 0);

        run_cmd("ignored_start", 30, 12, 3);
`ifdef IF_READER_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, 6);
`endif

        repeat (4) run_cmd("random", $urandom_range(0, 255), $urandom_range(1, 40), 1);
        run_cmd("clamp", 230, 300, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
